// File: rtl/morse_decoder_pkg.sv
// morse_decoder_pkg
//   Shared definitions for the morse receiver: frame width, the S..Z
//   16-symbol patterns (MSB = first symbol on the wire), letter codes and
//   the decoder FSM state encoding.
//   Optional build macro used by this block: MORSE_DECODER_EARLY_END_EN.
package morse_decoder_pkg;

  localparam int FRAME_BITS = 16;

  // 1 = mark. Dot = 1 unit, dash = 3 units, 1-unit gap between elements.
  localparam logic [15:0] PAT_S = 16'b1010100000000000;
  localparam logic [15:0] PAT_T = 16'b1110000000000000;
  localparam logic [15:0] PAT_U = 16'b1010111000000000;
  localparam logic [15:0] PAT_V = 16'b1010101110000000;
  localparam logic [15:0] PAT_W = 16'b1011101110000000;
  localparam logic [15:0] PAT_X = 16'b1110101011100000;
  localparam logic [15:0] PAT_Y = 16'b1110101110111000;
  localparam logic [15:0] PAT_Z = 16'b1110111010100000;

  localparam logic [2:0] LTR_S = 3'd0;
  localparam logic [2:0] LTR_T = 3'd1;
  localparam logic [2:0] LTR_U = 3'd2;
  localparam logic [2:0] LTR_V = 3'd3;
  localparam logic [2:0] LTR_W = 3'd4;
  localparam logic [2:0] LTR_X = 3'd5;
  localparam logic [2:0] LTR_Y = 3'd6;
  localparam logic [2:0] LTR_Z = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_MATCH   = 2'd2
  } state_t;

  // Pattern for a given letter code.
  function automatic logic [15:0] pattern_of(input logic [2:0] code);
    logic [15:0] p;
    p = PAT_S;
    case (code)
      LTR_S:   p = PAT_S;
      LTR_T:   p = PAT_T;
      LTR_U:   p = PAT_U;
      LTR_V:   p = PAT_V;
      LTR_W:   p = PAT_W;
      LTR_X:   p = PAT_X;
      LTR_Y:   p = PAT_Y;
      default: p = PAT_Z;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/morse_decoder_symbol_timer.sv
// morse_decoder_symbol_timer
//   Loadable down-counter that marks symbol sample points. Unlike a
//   free-running divider its phase is set by `load`, so each frame can be
//   aligned to its own leading mark edge.
// Ports:
//   clock       system clock
//   reset       asynchronous active-low reset
//   load        load `load_value` this cycle (wins over counting)
//   load_value  next count value
//   enable      count down while high
//   tick        high while enabled and the count has reached zero
module morse_decoder_symbol_timer #(
  parameter int SYMBOL_CYCLES = 25000000,
  localparam int TW = $clog2(SYMBOL_CYCLES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  input  logic          enable,
  output logic          tick
);

  logic [TW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder
//   Receives the serial morse stream, re-times it to mid-symbol sample
//   points, captures one frame starting at the first mark and matches it
//   against the S..Z patterns.
//   Optional build macro: MORSE_DECODER_EARLY_END_EN -- capture also ends
//   after three consecutive 0 samples that follow a 1; the frame is then
//   zero-filled to full width before matching.
// Ports:
//   clock         system clock
//   reset         asynchronous active-low reset
//   morse_code    serial stream, 1 = mark, asynchronous to symbol phase
//   letter        decoded letter code (000 = S .. 111 = Z)
//   letter_valid  one-cycle pulse, `letter` carries the new code
//   decode_error  one-cycle pulse, frame matched no pattern
//   busy          high in CAPTURE or MATCH
//   dbg_state     current FSM state
// Handshake: letter_valid / decode_error are fire-and-forget one-cycle
// pulses with no ready; they are mutually exclusive and only occur in MATCH.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       morse_code,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       decode_error,
  output logic       busy,
  output state_t     dbg_state
);

  localparam int TW = $clog2(SYMBOL_CYCLES);
  localparam logic [TW-1:0] HALF_LOAD = TW'(SYMBOL_CYCLES / 2);
  localparam logic [TW-1:0] FULL_LOAD = TW'(SYMBOL_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT  = 5'(FRAME_BITS - 1);
  localparam logic [4:0]    FULL_CNT  = 5'(FRAME_BITS);

  state_t                  state, state_next;
  logic [1:0]              sync;
  logic                    ms, ms_prev, rise;
  logic                    tick, timer_load;
  logic [TW-1:0]           timer_value;
  logic [FRAME_BITS-1:0]   shreg, shreg_shift, shreg_next;
  logic [4:0]              bit_cnt;
  logic [2:0]              letter_q, match_idx;
  logic                    hit, capture_done, early_end, glitch;

  // {hit, index} of the pattern equal to the frame.
  function automatic logic [3:0] match_frame(input logic [FRAME_BITS-1:0] f);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 0; i < 8; i++) begin
      if (f == pattern_of(3'(i))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync    <= 2'b00;
      ms_prev <= 1'b0;
    end else begin
      sync    <= {sync[0], morse_code};
      ms_prev <= sync[1];
    end
  end

  assign ms   = sync[1];
  assign rise = ms && !ms_prev;

  morse_decoder_symbol_timer #(.SYMBOL_CYCLES(SYMBOL_CYCLES)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (state == ST_CAPTURE),
    .tick       (tick)
  );

`ifdef MORSE_DECODER_EARLY_END_EN
  logic [1:0] zero_run;
  logic       seen_one;

  // Third consecutive 0 after a mark is the inter-letter gap.
  assign early_end = seen_one && (zero_run == 2'd2) && !ms;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zero_run <= 2'd0;
      seen_one <= 1'b0;
    end else if ((state == ST_IDLE) && rise) begin
      zero_run <= 2'd0;
      seen_one <= 1'b0;
    end else if ((state == ST_CAPTURE) && tick) begin
      if (ms) begin
        zero_run <= 2'd0;
        seen_one <= 1'b1;
      end else if (zero_run != 2'd3) begin
        zero_run <= zero_run + 2'd1;
      end
    end
  end
`else
  assign early_end = 1'b0;
`endif

  assign glitch       = (bit_cnt == 5'd0) && !ms;
  assign capture_done = (bit_cnt == LAST_BIT) || early_end;
  assign shreg_shift  = {shreg[FRAME_BITS-2:0], ms};
  // On an early end, left-align the captured symbols so the pattern
  // compare sees the same zero-padded frame as a full capture.
  assign shreg_next   = early_end ? (shreg_shift << (LAST_BIT - bit_cnt))
                                  : shreg_shift;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = HALF_LOAD;
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next  = ST_CAPTURE;
          timer_load  = 1'b1;
          timer_value = HALF_LOAD;
        end
      end
      ST_CAPTURE: begin
        if (tick) begin
          timer_load  = 1'b1;
          timer_value = FULL_LOAD;
          if (glitch)            state_next = ST_IDLE;
          else if (capture_done) state_next = ST_MATCH;
        end
      end
      ST_MATCH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      bit_cnt  <= 5'd0;
      letter_q <= 3'd0;
    end else if ((state == ST_IDLE) && rise) begin
      shreg   <= '0;
      bit_cnt <= 5'd0;
    end else if ((state == ST_CAPTURE) && tick) begin
      shreg <= shreg_next;
      if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + 5'd1;
    end else if ((state == ST_MATCH) && hit) begin
      letter_q <= match_idx;
    end
  end

  assign {hit, match_idx} = match_frame(shreg);

  // The new code is presented in the same cycle as its valid pulse.
  assign letter_valid = (state == ST_MATCH) && hit;
  assign decode_error = (state == ST_MATCH) && !hit;
  assign letter       = letter_valid ? match_idx : letter_q;
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;

endmodule
